// File: rtl/hsck_pkg.sv
// -----------------------------------------------------------------------------
// hsck_pkg
// Shared definitions for the HSCK frame controller.
//   FRAME_LEN_MIN/MAX : legal range of HSCK cycles per frame
//   N_CH_MAX          : widest supported channel-pair count
//   ch_req_t          : per-channel start/stop request vector (widest case)
//   hsck_cw()         : counter/window width for a given frame length
// No ports (package).
// -----------------------------------------------------------------------------
package hsck_pkg;

  localparam int FRAME_LEN_MIN = 2;
  localparam int FRAME_LEN_MAX = 1024;
  localparam int N_CH_MAX      = 8;

  typedef logic [N_CH_MAX-1:0] ch_req_t;

  // Bits needed to hold counts 0 .. frame_len-1.
  function automatic int hsck_cw(input int frame_len);
    return $clog2(frame_len);
  endfunction

endpackage

// File: rtl/hsck_window_dec.sv
// -----------------------------------------------------------------------------
// hsck_window_dec
// Captures the shift window bounds once per frame, clamps an out-of-range
// upper bound to the last legal count, and decodes the window against the
// current frame count.
// Ports:
//   clock   in   HSCK domain clock
//   reset   in   synchronous, active-high reset
//   run     in   frame counter enable (window forced off when low)
//   last    in   frame-boundary flag; bounds are captured only here
//   count   in   current frame count (CW bits)
//   win_lo  in   window first count, inclusive (CW bits)
//   win_hi  in   window last count, inclusive (CW bits)
//   win     out  window active this cycle
//   cfg_err out  sticky flag: a captured win_hi was >= FRAME_LEN
// -----------------------------------------------------------------------------
module hsck_window_dec
  import hsck_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int CW        = hsck_cw(FRAME_LEN)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          last,
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] win_lo,
  input  logic [CW-1:0] win_hi,
  output logic          win,
  output logic          cfg_err
);

  // One extra bit so FRAME_LEN itself is representable when CW is exact.
  localparam logic [CW:0]   LEN_EXT = (CW+1)'(FRAME_LEN);
  localparam logic [CW-1:0] MAX_CNT = CW'(FRAME_LEN - 1);

  logic [CW-1:0] shadow_lo;
  logic [CW-1:0] shadow_hi;
  logic          hi_over;

  assign hi_over = ({1'b0, win_hi} >= LEN_EXT);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_lo <= '0;
      shadow_hi <= '0;
      cfg_err   <= 1'b0;
    end else if (last) begin
      shadow_lo <= win_lo;
      shadow_hi <= hi_over ? MAX_CNT : win_hi;
      if (hi_over) begin
        cfg_err <= 1'b1;
      end
    end
  end

  // lo > hi naturally yields an empty window: no count satisfies both bounds.
  assign win = run && (count >= shadow_lo) && (count <= shadow_hi);

endmodule

// File: rtl/hsck_frame_ctrl.sv
// -----------------------------------------------------------------------------
// hsck_frame_ctrl
// Frame sequencer for an HSCK-clocked serial interface. A down-counter walks
// FRAME_LEN-1 .. 0; a per-frame shift window and per-channel enables, both
// refreshed only at the frame boundary, produce shift enables and
// word-complete pulses for N_CH input/output channel pairs.
//
// Optional feature: define HSCK_GATED_CLK_EN to drive masked_hsck with the
// clock gated by the window (latch-based gate). Otherwise masked_hsck is 0.
//
// Ports:
//   clock          in   HSCK domain clock (sole clock)
//   reset          in   synchronous, active-high reset
//   run            in   frame counter enable
//   win_lo         in   window first count, inclusive (CW)
//   win_hi         in   window last count, inclusive (CW)
//   in_start_stop  in   per-channel input shift request (N_CH)
//   out_start_stop in   per-channel output shift request (N_CH)
//   count          out  current frame count (CW)
//   last           out  frame-boundary flag, run & (count == 0)
//   win            out  shift window active
//   in_shift       out  per-channel input shift enable (N_CH)
//   out_shift      out  per-channel output shift enable (N_CH)
//   in_next        out  per-channel input word-complete pulse (N_CH)
//   out_next       out  per-channel output word-complete pulse (N_CH)
//   cfg_err        out  sticky window-configuration error
//   masked_hsck    out  gated clock (see HSCK_GATED_CLK_EN)
// -----------------------------------------------------------------------------
module hsck_frame_ctrl
  import hsck_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int N_CH      = 1,
  parameter int CW        = hsck_cw(FRAME_LEN)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [CW-1:0]   win_lo,
  input  logic [CW-1:0]   win_hi,
  input  logic [N_CH-1:0] in_start_stop,
  input  logic [N_CH-1:0] out_start_stop,
  output logic [CW-1:0]   count,
  output logic            last,
  output logic            win,
  output logic [N_CH-1:0] in_shift,
  output logic [N_CH-1:0] out_shift,
  output logic [N_CH-1:0] in_next,
  output logic [N_CH-1:0] out_next,
  output logic            cfg_err,
  output logic            masked_hsck
);

  localparam logic [CW-1:0] MAX_CNT = CW'(FRAME_LEN - 1);

  logic [N_CH-1:0] in_en;
  logic [N_CH-1:0] out_en;

  // Frame counter: counts down, wraps 0 -> FRAME_LEN-1, freezes while !run.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (run) begin
      count <= (count == '0) ? MAX_CNT : count - CW'(1);
    end
  end

  assign last = run && (count == '0);

  // Requests are sampled only at the boundary, so anything that toggles and
  // returns between two boundaries is invisible to the frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_en  <= '0;
      out_en <= '0;
    end else if (last) begin
      in_en  <= in_start_stop;
      out_en <= out_start_stop;
    end
  end

  hsck_window_dec #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_window_dec (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .last    (last),
    .count   (count),
    .win_lo  (win_lo),
    .win_hi  (win_hi),
    .win     (win),
    .cfg_err (cfg_err)
  );

  // win and last already include run, so a paused frame drives no shifts.
  assign in_shift  = in_en  & {N_CH{win}};
  assign out_shift = out_en & {N_CH{win}};
  // Word-complete uses the enable of the frame just ending (pre-update value).
  assign in_next   = in_en  & {N_CH{last}};
  assign out_next  = out_en & {N_CH{last}};

`ifdef HSCK_GATED_CLK_EN
  logic gate_en;

  // NOTE: this latch is intentional. It is transparent only while clock is
  // low, so win may settle freely then and is frozen through the high phase,
  // which keeps the AND below free of glitches and runt pulses.
  always_latch begin
    if (!clock) begin
      gate_en = win;
    end
  end

  assign masked_hsck = clock & gate_en;
`else
  assign masked_hsck = 1'b0;
`endif

endmodule

// File: tb/tb_hsck_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hsck_frame_ctrl
// Directed bench for hsck_frame_ctrl with FRAME_LEN=64, N_CH=2 and CW=7 (one
// spare bit so an out-of-range win_hi such as 70 can be presented).
// A table of {inputs, expected outputs} walks the first frames after reset;
// hand-written sequences cover window reconfiguration, clamping, pause,
// mid-frame reset and the gated clock output.
// -----------------------------------------------------------------------------
module tb_hsck_frame_ctrl;
  import hsck_pkg::*;

  localparam int FL = 64;
  localparam int NC = 2;
  localparam int CW = 7;

`ifdef HSCK_GATED_CLK_EN
  localparam int EXP_MASK_PULSES = 16;
`else
  localparam int EXP_MASK_PULSES = 0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          run;
  logic [CW-1:0] win_lo;
  logic [CW-1:0] win_hi;
  logic [NC-1:0] in_start_stop;
  logic [NC-1:0] out_start_stop;
  logic [CW-1:0] count;
  logic          last;
  logic          win;
  logic [NC-1:0] in_shift;
  logic [NC-1:0] out_shift;
  logic [NC-1:0] in_next;
  logic [NC-1:0] out_next;
  logic          cfg_err;
  logic          masked_hsck;

  hsck_frame_ctrl #(
    .FRAME_LEN (FL),
    .N_CH      (NC),
    .CW        (CW)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .win_lo         (win_lo),
    .win_hi         (win_hi),
    .in_start_stop  (in_start_stop),
    .out_start_stop (out_start_stop),
    .count          (count),
    .last           (last),
    .win            (win),
    .in_shift       (in_shift),
    .out_shift      (out_shift),
    .in_next        (in_next),
    .out_next       (out_next),
    .cfg_err        (cfg_err),
    .masked_hsck    (masked_hsck)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; leaves time just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for the frame counter to reach a given value.
  task automatic advance_to(input int target);
    int n;
    n = 0;
    while (int'(count) != target && n < 130) begin
      tick();
      n++;
    end
    check($sformatf("reach_count_%0d", target), count, target);
  endtask

  typedef struct {
    int            adv;
    ch_req_t       in_req;
    ch_req_t       out_req;
    int            e_count;
    logic          e_last;
    logic          e_win;
    logic [NC-1:0] e_in_shift;
    logic [NC-1:0] e_out_shift;
    logic [NC-1:0] e_in_next;
    logic [NC-1:0] e_out_next;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input int adv, input int ir, input int orq, input int c,
                              input int l, input int w, input int is, input int os,
                              input int inx, input int onx);
    vec_t v;
    v.adv         = adv;
    v.in_req      = ch_req_t'(ir);
    v.out_req     = ch_req_t'(orq);
    v.e_count     = c;
    v.e_last      = l[0];
    v.e_win       = w[0];
    v.e_in_shift  = NC'(is);
    v.e_out_shift = NC'(os);
    v.e_in_next   = NC'(inx);
    v.e_out_next  = NC'(onx);
    return v;
  endfunction

  int n_win, n_last, n_shift, n_next, n_mask_hi, n_mask_lo;

  initial begin
    // k = edges since reset release; count = (-k) mod 64; window 8..23.
    //            adv  in out  cnt last win ish osh inx onx
    vecs[0]  = mk(  0, 0, 0,    0, 1, 1,  0,  0,  0,  0); // window still 0..0
    vecs[1]  = mk(  1, 0, 0,   63, 0, 0,  0,  0,  0,  0);
    vecs[2]  = mk( 19, 1, 2,   44, 0, 0,  0,  0,  0,  0); // requests arrive mid-frame
    vecs[3]  = mk( 21, 1, 2,   23, 0, 1,  0,  0,  0,  0); // not yet enabled
    vecs[4]  = mk( 15, 1, 2,    8, 0, 1,  0,  0,  0,  0);
    vecs[5]  = mk(  1, 1, 2,    7, 0, 0,  0,  0,  0,  0);
    vecs[6]  = mk(  7, 1, 2,    0, 1, 0,  0,  0,  0,  0); // next uses old enables
    vecs[7]  = mk(  1, 1, 2,   63, 0, 0,  0,  0,  0,  0);
    vecs[8]  = mk( 40, 1, 2,   23, 0, 1,  1,  2,  0,  0);
    vecs[9]  = mk( 15, 1, 2,    8, 0, 1,  1,  2,  0,  0);
    vecs[10] = mk(  1, 1, 2,    7, 0, 0,  0,  0,  0,  0);
    vecs[11] = mk(  7, 1, 2,    0, 1, 0,  0,  0,  1,  2);
    vecs[12] = mk( 42, 1, 2,   22, 0, 1,  1,  2,  0,  0);
    vecs[13] = mk(  5, 0, 2,   17, 0, 1,  1,  2,  0,  0); // drop ignored mid-frame
    vecs[14] = mk( 58, 1, 2,   23, 0, 1,  1,  2,  0,  0); // restored before boundary

    reset          = 1'b1;
    run            = 1'b0;
    win_lo         = CW'(8);
    win_hi         = CW'(23);
    in_start_stop  = '0;
    out_start_stop = '0;
    tick();
    tick();

    check("rst_count",   count,    0);
    check("rst_last",    last,     0);
    check("rst_win",     win,      0);
    check("rst_cfg_err", cfg_err,  0);
    check("rst_in_shift", in_shift, 0);
    run = 1'b1;
    #1;
    check("rst_run_last", last, 1);
    check("rst_run_win",  win,  1);
    check("rst_run_next", in_next, 0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      in_start_stop  = vecs[i].in_req[NC-1:0];
      out_start_stop = vecs[i].out_req[NC-1:0];
      repeat (vecs[i].adv) tick();
      #1;
      check($sformatf("v%0d_count", i),     count,     vecs[i].e_count);
      check($sformatf("v%0d_last", i),      last,      vecs[i].e_last);
      check($sformatf("v%0d_win", i),       win,       vecs[i].e_win);
      check($sformatf("v%0d_in_shift", i),  in_shift,  vecs[i].e_in_shift);
      check($sformatf("v%0d_out_shift", i), out_shift, vecs[i].e_out_shift);
      check($sformatf("v%0d_in_next", i),   in_next,   vecs[i].e_in_next);
      check($sformatf("v%0d_out_next", i),  out_next,  vecs[i].e_out_next);
    end

    // One full frame of activity: 16 window cycles, one boundary.
    n_win = 0; n_last = 0; n_shift = 0; n_next = 0;
    for (int i = 0; i < FL; i++) begin
      tick();
      n_win   += int'(win);
      n_last  += int'(last);
      n_shift += int'(in_shift[0]);
      n_next  += int'(in_next[0]);
    end
    check("frame_win_cycles",  n_win,   16);
    check("frame_last_cycles", n_last,  1);
    check("frame_in_shift0",   n_shift, 16);
    check("frame_in_next0",    n_next,  1);

    // Window low bound moved mid-frame: current frame unaffected.
    advance_to(40);
    win_lo = CW'(30);
    advance_to(23);
    check("lo_chg_cur_win23", win, 1);
    advance_to(8);
    check("lo_chg_cur_win8", win, 1);
    tick();
    check("lo_chg_cur_win7", win, 0);
    advance_to(0);
    tick();
    n_win = 0;
    for (int i = 0; i < FL; i++) begin
      n_win += int'(win);
      tick();
    end
    check("lo_chg_empty_window", n_win, 0);
    check("lo_chg_cfg_err", cfg_err, 0);

    // Upper bound beyond the frame: clamps to 63 and flags cfg_err.
    win_lo = CW'(8);
    win_hi = CW'(70);
    advance_to(0);
    check("clamp_err_before", cfg_err, 0);
    tick();
    check("clamp_err_set", cfg_err, 1);
    check("clamp_win63",   win,     1);
    advance_to(8);
    check("clamp_win8", win, 1);
    tick();
    check("clamp_win7", win, 0);
    win_hi = CW'(23);
    advance_to(0);
    tick();
    check("clamp_restored_win63", win,     0);
    check("clamp_err_sticky",     cfg_err, 1);

    // Pause mid-window: count holds, outputs quiet, resumes from held count.
    advance_to(20);
    check("pause_pre_in_shift", in_shift, 1);
    run = 1'b0;
    #1;
    check("pause_win",       win,       0);
    check("pause_in_shift",  in_shift,  0);
    check("pause_out_shift", out_shift, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("pause_count_%0d", i), count, 20);
      check($sformatf("pause_shift_%0d", i), {in_shift, out_shift}, 0);
    end
    run = 1'b1;
    #1;
    check("resume_in_shift", in_shift, 1);
    tick();
    check("resume_count", count, 19);

    // Pause exactly on the boundary suppresses last and next.
    advance_to(0);
    check("bnd_last",    last,    1);
    check("bnd_in_next", in_next, 1);
    run = 1'b0;
    #1;
    check("bnd_pause_last",    last,     0);
    check("bnd_pause_in_next", in_next,  0);
    check("bnd_pause_out_nxt", out_next, 0);
    tick();
    check("bnd_pause_count", count, 0);
    run = 1'b1;
    #1;
    check("bnd_resume_last", last, 1);

    // Reset mid-frame abandons the frame and clears enables and cfg_err.
    advance_to(12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_count",     count,     0);
    check("mid_rst_cfg_err",   cfg_err,   0);
    check("mid_rst_last",      last,      1);
    check("mid_rst_win",       win,       1);
    check("mid_rst_in_shift",  in_shift,  0);
    check("mid_rst_out_shift", out_shift, 0);
    check("mid_rst_in_next",   in_next,   0);
    tick();
    check("mid_rst_wrap", count, 63);

    // Gated clock: high-phase pulses only for window cycles, never low.
    n_mask_hi = 0; n_mask_lo = 0;
    for (int i = 0; i < FL; i++) begin
      tick();
      n_mask_hi += int'(masked_hsck);
      #5;
      n_mask_lo += int'(masked_hsck);
    end
    check("mask_high_pulses", n_mask_hi, EXP_MASK_PULSES);
    check("mask_low_phase",   n_mask_lo, 0);
`ifdef HSCK_GATED_CLK_EN
    advance_to(23);
    check("mask_edge_in_23", masked_hsck, 0);
    tick();
    check("mask_edge_in_22", masked_hsck, 1);
    advance_to(7);
    check("mask_edge_out_7", masked_hsck, 1);
    tick();
    check("mask_edge_out_6", masked_hsck, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
